// File: rtl/dmem_arb_pkg.sv
// Shared types and widths for the two-requester byte-wide data memory arbiter.
package dmem_arb_pkg;

   localparam int unsigned LANE_W    = 8;
   localparam int unsigned WADDR_W   = 6;
   localparam int unsigned NUM_LANES = 4;
   localparam int unsigned LANE_SEL_W = 2;
   localparam int unsigned WORD_W    = LANE_W * NUM_LANES;
   localparam int unsigned BADDR_W   = WADDR_W + LANE_SEL_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RDATA = 2'd2
   } arb_state_e;

   // Part of the granted command that must survive past the issue cycle
   typedef struct packed {
      logic                  we;
      logic [LANE_SEL_W-1:0] lane;
      logic                  owner;
   } cmd_t;

endpackage

// File: rtl/byte_lane_mux.sv
// Combinational byte lane steering: read lane select, write replicate and lane enable.
module byte_lane_mux
   import dmem_arb_pkg::*;
(
   input  logic [LANE_SEL_W-1:0] lane_i,
   input  logic [LANE_W-1:0]     wbyte_i,
   input  logic [WORD_W-1:0]     rword_i,
   output logic [NUM_LANES-1:0]  be_o,
   output logic [WORD_W-1:0]     wword_o,
   output logic [LANE_W-1:0]     rbyte_o
);

   // One-hot lane enable and byte replicated across the word
   always_comb begin
      be_o         = '0;
      be_o[lane_i] = 1'b1;
      wword_o      = {NUM_LANES{wbyte_i}};
   end

   // Pick the addressed byte out of the read word
   always_comb begin
      rbyte_o = '0;
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
         if (lane_i == LANE_SEL_W'(i)) begin
            rbyte_o = rword_i[i*LANE_W +: LANE_W];
         end
      end
   end

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates a processor and a loader/debug port onto one single-port data memory.
module data_mem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned FIXED_PRIO = 0
)
(
   input  logic                 clk,
   input  logic                 reset,

   input  logic                 r0_req,
   input  logic                 r0_we,
   input  logic [BADDR_W-1:0]   r0_addr,
   input  logic [LANE_W-1:0]    r0_wdata,
   output logic                 r0_gnt,
   output logic                 r0_rvalid,
   output logic [LANE_W-1:0]    r0_rdata,

   input  logic                 r1_req,
   input  logic                 r1_we,
   input  logic [BADDR_W-1:0]   r1_addr,
   input  logic [LANE_W-1:0]    r1_wdata,
   output logic                 r1_gnt,
   output logic                 r1_rvalid,
   output logic [LANE_W-1:0]    r1_rdata,

   output logic [WADDR_W-1:0]   mem_addr,
   output logic [WORD_W-1:0]    mem_wdata,
   output logic [NUM_LANES-1:0] mem_be,
   output logic                 mem_we,
   input  logic [WORD_W-1:0]    mem_rdata
);

   arb_state_e            state_q, state_d;
   logic                  last_q, last_d;
   cmd_t                  cmd_q, cmd_d;
   logic                  gnt0_q, gnt0_d;
   logic                  gnt1_q, gnt1_d;
   logic                  rv0_q, rv0_d;
   logic                  rv1_q, rv1_d;
   logic [LANE_W-1:0]     rdata0_q, rdata0_d;
   logic [LANE_W-1:0]     rdata1_q, rdata1_d;
   logic [WADDR_W-1:0]    mem_addr_q, mem_addr_d;
   logic [WORD_W-1:0]     mem_wdata_q, mem_wdata_d;
   logic [NUM_LANES-1:0]  mem_be_q, mem_be_d;
   logic                  mem_we_q, mem_we_d;

   logic                  pick1;
   logic                  win_we;
   logic [BADDR_W-1:0]    win_addr;
   logic [LANE_W-1:0]     win_wdata;
   logic [LANE_SEL_W-1:0] lane_sel;
   logic [NUM_LANES-1:0]  mux_be;
   logic [WORD_W-1:0]     mux_wword;
   logic [LANE_W-1:0]     mux_rbyte;

   // Winner selection: requester 1 wins alone, or on a tie when round-robin says so
   always_comb begin
      pick1 = r1_req;
      if (r0_req && r1_req) begin
         if (FIXED_PRIO != 0) begin
            pick1 = 1'b0;
         end else begin
            pick1 = ~last_q;
         end
      end
      win_we    = pick1 ? r1_we    : r0_we;
      win_addr  = pick1 ? r1_addr  : r0_addr;
      win_wdata = pick1 ? r1_wdata : r0_wdata;
   end

   // Lane comes from the live winner when granting, from the latched command afterwards
   always_comb begin
      lane_sel = (state_q == IDLE) ? win_addr[LANE_SEL_W-1:0] : cmd_q.lane;
   end

   byte_lane_mux u_lane_mux (
      .lane_i  (lane_sel),
      .wbyte_i (win_wdata),
      .rword_i (mem_rdata),
      .be_o    (mux_be),
      .wword_o (mux_wword),
      .rbyte_o (mux_rbyte)
   );

   // Next-state and next-output logic; strobes default low, data holds
   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      cmd_d       = cmd_q;
      gnt0_d      = 1'b0;
      gnt1_d      = 1'b0;
      rv0_d       = 1'b0;
      rv1_d       = 1'b0;
      rdata0_d    = rdata0_q;
      rdata1_d    = rdata1_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_be_d    = '0;
      mem_we_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (r0_req || r1_req) begin
               state_d     = ISSUE;
               last_d      = pick1;
               cmd_d.we    = win_we;
               cmd_d.lane  = win_addr[LANE_SEL_W-1:0];
               cmd_d.owner = pick1;
               gnt0_d      = ~pick1;
               gnt1_d      = pick1;
               mem_addr_d  = win_addr[BADDR_W-1:LANE_SEL_W];
               mem_wdata_d = mux_wword;
               mem_be_d    = mux_be;
               mem_we_d    = win_we;
            end
         end
         ISSUE: begin
            state_d = cmd_q.we ? IDLE : RDATA;
         end
         RDATA: begin
            state_d = IDLE;
            if (cmd_q.owner) begin
               rdata1_d = mux_rbyte;
               rv1_d    = 1'b1;
            end else begin
               rdata0_d = mux_rbyte;
               rv0_d    = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; reset favours requester 0 on the first tie
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         last_q      <= 1'b1;
         cmd_q       <= '0;
         gnt0_q      <= 1'b0;
         gnt1_q      <= 1'b0;
         rv0_q       <= 1'b0;
         rv1_q       <= 1'b0;
         rdata0_q    <= '0;
         rdata1_q    <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_be_q    <= '0;
         mem_we_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         cmd_q       <= cmd_d;
         gnt0_q      <= gnt0_d;
         gnt1_q      <= gnt1_d;
         rv0_q       <= rv0_d;
         rv1_q       <= rv1_d;
         rdata0_q    <= rdata0_d;
         rdata1_q    <= rdata1_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_be_q    <= mem_be_d;
         mem_we_q    <= mem_we_d;
      end
   end

   assign r0_gnt    = gnt0_q;
   assign r1_gnt    = gnt1_q;
   assign r0_rvalid = rv0_q;
   assign r1_rvalid = rv1_q;
   assign r0_rdata  = rdata0_q;
   assign r1_rdata  = rdata1_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_be    = mem_be_q;
   assign mem_we    = mem_we_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: round-robin instance plus a fixed-priority twin.
module tb_data_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        r0_req, r0_we, r1_req, r1_we;
   logic [7:0]  r0_addr, r0_wdata, r1_addr, r1_wdata;

   logic        g0, g1, v0, v1, mwe;
   logic [7:0]  rd0, rd1;
   logic [5:0]  maddr;
   logic [31:0] mwdata, mrd;
   logic [3:0]  mbe;

   logic        fg0, fg1, fv0, fv1, fmwe;
   logic [7:0]  frd0, frd1;
   logic [5:0]  fmaddr;
   logic [31:0] fmwdata, fmrd;
   logic [3:0]  fmbe;

   logic [31:0] mem [64];

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   data_mem_arbiter #(.FIXED_PRIO(0)) dut (
      .clk(clk), .reset(reset),
      .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
      .r0_gnt(g0), .r0_rvalid(v0), .r0_rdata(rd0),
      .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
      .r1_gnt(g1), .r1_rvalid(v1), .r1_rdata(rd1),
      .mem_addr(maddr), .mem_wdata(mwdata), .mem_be(mbe), .mem_we(mwe),
      .mem_rdata(mrd)
   );

   data_mem_arbiter #(.FIXED_PRIO(1)) dut_fp (
      .clk(clk), .reset(reset),
      .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
      .r0_gnt(fg0), .r0_rvalid(fv0), .r0_rdata(frd0),
      .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
      .r1_gnt(fg1), .r1_rvalid(fv1), .r1_rdata(frd1),
      .mem_addr(fmaddr), .mem_wdata(fmwdata), .mem_be(fmbe), .mem_we(fmwe),
      .mem_rdata(fmrd)
   );

   // Synchronous-read memory model, one read port per instance
   always @(posedge clk) begin
      mrd  <= mem[maddr];
      fmrd <= mem[fmaddr];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'h01010101 * i;
      mem[0] = 32'hDDCCBBAA;
      mem[1] = 32'h87654321;
      mem[4] = 32'h44332211;

      reset = 1'b1;
      r0_req = 1'b0; r0_we = 1'b0; r0_addr = 8'h00; r0_wdata = 8'h00;
      r1_req = 1'b0; r1_we = 1'b0; r1_addr = 8'h00; r1_wdata = 8'h00;
      tick();
      tick();
      check("rst_gnt", {30'd0, g1, g0}, 32'd0);
      check("rst_rvalid", {30'd0, v1, v0}, 32'd0);
      check("rst_mem_be_we", {27'd0, mwe, mbe}, 32'd0);
      check("rst_mem_addr", 32'(maddr), 32'd0);
      check("rst_mem_wdata", mwdata, 32'd0);
      reset = 1'b0;

      // Idle with no request
      tick();
      check("idle_be_we", {27'd0, mwe, mbe}, 32'd0);
      check("idle_gnt", {30'd0, g1, g0}, 32'd0);

      // Single write by r0: addr 0x0D, data 0xA5
      r0_req = 1'b1; r0_we = 1'b1; r0_addr = 8'h0D; r0_wdata = 8'hA5;
      tick();
      check("wr_gnt", {30'd0, g1, g0}, 32'd1);
      check("wr_mem_addr", 32'(maddr), 32'h03);
      check("wr_mem_be", 32'(mbe), 32'b0010);
      check("wr_mem_wdata", mwdata, 32'hA5A5A5A5);
      check("wr_mem_we", 32'(mwe), 32'd1);
      r0_req = 1'b0;
      tick();
      check("wr_after_gnt", {30'd0, g1, g0}, 32'd0);
      check("wr_after_be_we", {27'd0, mwe, mbe}, 32'd0);
      check("wr_hold_addr", 32'(maddr), 32'h03);
      check("wr_hold_wdata", mwdata, 32'hA5A5A5A5);

      // Single read by r1: addr 0x13 -> word 4 lane 3
      r1_req = 1'b1; r1_we = 1'b0; r1_addr = 8'h13; r1_wdata = 8'h00;
      tick();
      check("rd_gnt", {30'd0, g1, g0}, 32'd2);
      check("rd_mem_addr", 32'(maddr), 32'h04);
      check("rd_mem_be_we", {27'd0, mwe, mbe}, {27'd0, 1'b0, 4'b1000});
      r1_req = 1'b0;
      tick();
      check("rd_n2_rvalid", {30'd0, v1, v0}, 32'd0);
      check("rd_n2_be", 32'(mbe), 32'd0);
      tick();
      check("rd_n3_rvalid", {30'd0, v1, v0}, 32'd2);
      check("rd_n3_rdata", 32'(rd1), 32'h44);
      tick();
      check("rd_n4_rvalid", {30'd0, v1, v0}, 32'd0);
      check("rd_hold_rdata", 32'(rd1), 32'h44);

      // Request withdrawn before being sampled: no effect
      #1 r0_req = 1'b1; r0_we = 1'b1; r0_addr = 8'h2A; r0_wdata = 8'h77;
      #2 r0_req = 1'b0;
      tick();
      check("drop_gnt", {30'd0, g1, g0}, 32'd0);
      check("drop_be_we", {27'd0, mwe, mbe}, 32'd0);
      check("drop_addr", 32'(maddr), 32'h04);

      // Reset then continuous tie on writes
      reset = 1'b1;
      tick();
      check("rst2_rdata", 32'(rd1), 32'd0);
      reset = 1'b0;
      r0_req = 1'b1; r0_we = 1'b1; r0_addr = 8'h01; r0_wdata = 8'h11;
      r1_req = 1'b1; r1_we = 1'b1; r1_addr = 8'h22; r1_wdata = 8'h22;
      for (int k = 0; k < 4; k++) begin
         tick();
         check("tie_rr_gnt", {30'd0, g1, g0}, (k % 2 == 0) ? 32'd1 : 32'd2);
         check("tie_rr_addr", 32'(maddr), (k % 2 == 0) ? 32'h00 : 32'h08);
         check("tie_fp_gnt", {30'd0, fg1, fg0}, 32'd1);
         tick();
         check("tie_gap_gnt", {28'd0, fg1, fg0, g1, g0}, 32'd0);
      end
      r0_req = 1'b0; r1_req = 1'b0;
      tick();

      // Back-to-back reads by r0 to 0x00 and 0x03
      r0_req = 1'b1; r0_we = 1'b0; r0_addr = 8'h00; r0_wdata = 8'h00;
      tick();
      check("b2b_gnt_a", {30'd0, g1, g0}, 32'd1);
      r0_addr = 8'h03;
      tick();
      tick();
      check("b2b_rvalid_a", {30'd0, v1, v0}, 32'd1);
      check("b2b_rdata_a", 32'(rd0), 32'hAA);
      tick();
      check("b2b_gnt_b", {30'd0, g1, g0}, 32'd1);
      check("b2b_be_b", 32'(mbe), 32'b1000);
      r0_req = 1'b0;
      tick();
      check("b2b_mid_rvalid", {30'd0, v1, v0}, 32'd0);
      check("b2b_mid_rdata", 32'(rd0), 32'hAA);
      tick();
      check("b2b_rvalid_b", {30'd0, v1, v0}, 32'd1);
      check("b2b_rdata_b", 32'(rd0), 32'hDD);

      // Reset asserted while r0 read sits in RDATA
      r0_req = 1'b1; r0_we = 1'b0; r0_addr = 8'h07; r0_wdata = 8'h5A;
      tick();
      check("mr_gnt", {30'd0, g1, g0}, 32'd1);
      check("mr_mem_addr", 32'(maddr), 32'h01);
      r0_req = 1'b0;
      tick();
      #2 reset = 1'b1;
      #1;
      check("mr_rst_rdata", {16'd0, rd1, rd0}, 32'd0);
      check("mr_rst_mem_addr", 32'(maddr), 32'd0);
      check("mr_rst_mem_wdata", mwdata, 32'd0);
      check("mr_rst_strobes", {26'd0, v1, v0, g1, g0, mwe, mbe[0]}, 32'd0);
      tick();
      check("mr_no_rvalid", {30'd0, v1, v0}, 32'd0);
      reset = 1'b0;
      r0_req = 1'b1; r0_we = 1'b1; r0_addr = 8'h01; r0_wdata = 8'h11;
      r1_req = 1'b1; r1_we = 1'b1; r1_addr = 8'h22; r1_wdata = 8'h22;
      tick();
      check("mr_tie_gnt", {30'd0, g1, g0}, 32'd1);
      check("mr_no_late_rvalid", {30'd0, v1, v0}, 32'd0);
      r0_req = 1'b0; r1_req = 1'b0;
      tick();
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameter: FIXED_PRIO, default 0, meaning 1 = requester 0 always wins ties and 0 = round-robin.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 rN_req  input  1  requester N (N=0 processor, N=1 loader/debug) command pending; held with its fields until rN_gnt.
REQ-005 rN_we  input  1  1 = byte write, 0 = byte read.
REQ-006 rN_addr  input  8  byte address; [7:2] selects the word and [1:0] the lane.
REQ-007 rN_wdata  input  8  write byte.
REQ-008 rN_gnt  output  1  one-cycle pulse; the command is issued this cycle.
REQ-009 rN_rvalid  output  1  one-cycle pulse; rN_rdata is valid.
REQ-010 rN_rdata  output  8  read byte; held until that requester's next rvalid.
REQ-011 mem_addr  output  6  word address to the single-port data memory.
REQ-012 mem_wdata  output  32  write byte replicated on all 4 lanes.
REQ-013 mem_be  output  4  one-hot lane enable, equal to 1<<addr[1:0].
REQ-014 mem_we  output  1  write strobe.
REQ-015 mem_rdata  input  32  synchronous read data, valid one cycle after issue.

Function
REQ-016 FSM states are IDLE, ISSUE and RDATA; all outputs are registered.
REQ-017 IDLE with no request: stay in IDLE; mem_we=0 and mem_be=0.
REQ-018 IDLE with one request: latch that request's fields, go to ISSUE next cycle, and pulse its gnt in ISSUE.
REQ-019 IDLE with both requests and FIXED_PRIO=0: the requester not granted last wins; last_grant updates on every grant.
REQ-020 IDLE with both requests and FIXED_PRIO=1: requester 0 wins.
REQ-021 ISSUE: drive mem_addr=addr[7:2], mem_be=1<<addr[1:0], mem_wdata={4{wdata}}, and mem_we=we; requests are ignored in this state.
REQ-022 ISSUE on a write: go to IDLE; write latency is request-to-issue 1 cycle, and a new grant is possible 2 cycles after the previous grant.
REQ-023 ISSUE on a read: go to RDATA; in RDATA select lane addr[1:0] of mem_rdata into the winner's rdata, pulse its rvalid on the next cycle, and go to IDLE.
REQ-024 Read latency: req sampled in cycle N gives gnt in N+1 and rvalid in N+3.
REQ-025 Outside ISSUE, mem_we=0 and mem_be=0; mem_addr and mem_wdata hold their last value.
REQ-026 A loser's req stays pending; under continuous contention with FIXED_PRIO=0, no requester waits more than one transaction.
REQ-027 A req that deasserts before its gnt is dropped with no side effect.
REQ-028 A loser is never granted in the same transaction as the winner; at most one gnt and one rvalid are asserted per cycle.

Reset
REQ-029 Reset, asynchronous at any time including mid-ISSUE or mid-RDATA, sets state=IDLE and last_grant=1, so requester 0 wins the first tie.
REQ-030 Reset clears all gnt and rvalid outputs, rdata, mem_we, mem_be, mem_addr and mem_wdata to 0.
REQ-031 An in-flight read aborted by reset produces no rvalid.
REQ-032 Operation resumes on the first rising edge after reset deasserts.

Structure
REQ-033 Shared package dmem_arb_pkg holds the state encoding (IDLE/ISSUE/RDATA), the lane-width constant 8, and the word-address width 6.
REQ-034 One sub-module, byte_lane_mux, is combinational: lane select for reads and lane replicate/enable for writes; it is instantiated once.
REQ-035 Target size: 120-400 lines of RTL.

Verification
REQ-036 Single write: r0 writes addr 0x0D, data 0xA5 -> next cycle r0_gnt=1, mem_addr=0x03, mem_be=4'b0010, mem_wdata=0xA5A5A5A5, mem_we=1.
REQ-037 Single read: r1 reads addr 0x13 with memory word 0x44332211 at address 0x04 -> r1_gnt at N+1, then r1_rvalid=1 and r1_rdata=0x44 at N+3.
REQ-038 Tie: r0 and r1 request together after reset and keep requesting -> grants alternate r0,r1,r0,r1 with FIXED_PRIO=0, and are all r0 with FIXED_PRIO=1.
REQ-039 Reset mid-read: assert reset during RDATA -> no rvalid, all outputs 0, and the next tie goes to r0.
REQ-040 Back-to-back reads by r0 to 0x00 and 0x03 -> rdata shows lane 0 then lane 3, with rvalid pulses 3 cycles apart.
